gray_seq_ctrl: RTL and testbench

Sequencing controller for a Gray-code phase counter. Accepts a start request with a programmed lap count, steps the Gray phase up or down one code per cycle, supports hold and abort, and reports lap wraps and completion over a busy/done handshake. Sits between the phase-sequencing consumer (commutation/scan logic) and the Gray-code phase datapath, replacing the free-running counter with a controlled, countable one.

---
 rtl/gray_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_gray_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: sequencing controller for a Gray-code phase counter.
// Runs a programmed number of laps (2^WIDTH steps each) up or down. Hold
// freezes the phase and abort cancels the run. Lap wraps and completion are
// reported as one-cycle pulses. All outputs are registered.
module gray_seq_ctrl #(
  parameter int WIDTH = 3,
  parameter int LAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LAP_W-1:0] laps,
  input  logic             dir,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] idx;
  logic [WIDTH-1:0] idx_next;
  logic [LAP_W-1:0] laps_q;
  logic [LAP_W-1:0] lap_next;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
    return v ^ (v >> 1);
  endfunction

  // Candidate next index and lap count for a step in the sampled direction.
  always_comb begin
    idx_next = dir ? (idx - WIDTH'(1)) : (idx + WIDTH'(1));
    lap_next = lap_cnt + LAP_W'(1);
  end

  // Controller FSM with registered phase, lap count and handshake outputs.
  // NOTE: every register here uses <= so all state updates see the values
  // from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      laps_q  <= '0;
      gray    <= '0;
      wrap    <= 1'b0;
      lap_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // Pulse outputs fall back to zero unless set below.
      wrap <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          idx  <= '0;
          gray <= '0;
          if (start) begin
            lap_cnt <= '0;
            laps_q  <= laps;
            if (laps == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (abort) begin
            state <= IDLE;
            idx   <= '0;
            gray  <= '0;
            busy  <= 1'b0;
          end else if (hold) begin
            state <= HOLD;
          end else begin
            idx  <= idx_next;
            gray <= to_gray(idx_next);
            if (idx_next == '0) begin
              wrap    <= 1'b1;
              lap_cnt <= lap_next;
              if (lap_next == laps_q) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end

        HOLD: begin
          if (abort) begin
            state <= IDLE;
            idx   <= '0;
            gray  <= '0;
            busy  <= 1'b0;
          end else if (!hold) begin
            // Release only re-enters RUN; the next step happens one edge later.
            state <= RUN;
          end
        end

        DONE: begin
          // done was raised on entry; it drops here as we return to IDLE.
          state <= IDLE;
          idx   <= '0;
          gray  <= '0;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: self-checking bench for gray_seq_ctrl (WIDTH=3, LAP_W=4).
// Directed vector table, hand-written multi-cycle sequences, then random
// stimulus checked against a behavioural lap/phase model.
module tb_gray_seq_ctrl;

  localparam int WIDTH = 3;
  localparam int LAP_W = 4;
  localparam int STEPS = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             reset, start, dir, hold, abort;
  logic [LAP_W-1:0] laps;
  logic [WIDTH-1:0] gray;
  logic             wrap, busy, done;
  logic [LAP_W-1:0] lap_cnt;

  int checks = 0;
  int errors = 0;

  gray_seq_ctrl #(.WIDTH(WIDTH), .LAP_W(LAP_W)) dut (
    .clk(clk), .reset(reset), .start(start), .laps(laps), .dir(dir),
    .hold(hold), .abort(abort), .gray(gray), .wrap(wrap),
    .lap_cnt(lap_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase position 0..STEPS-1; the Gray code is read from the documented
  // up-sequence rather than computed.
  int  gray_seq [STEPS] = '{0, 1, 3, 2, 6, 7, 5, 4};
  int  m_pos, m_cnt, m_target;
  bit  m_busy, m_frozen, m_finishing, m_wrap, m_done;

  task automatic model_edge(input bit r, s, input int l, input bit d, h, a);
    m_wrap = 0;
    m_done = 0;
    if (r) begin
      m_pos = 0; m_cnt = 0; m_target = 0;
      m_busy = 0; m_frozen = 0; m_finishing = 0;
    end else if (m_finishing) begin
      m_finishing = 0;                    // completion cycle, inputs ignored
    end else if (!m_busy) begin
      if (s) begin
        m_target = l;
        m_cnt    = 0;
        if (l == 0) begin
          m_done = 1; m_finishing = 1;
        end else begin
          m_busy = 1; m_pos = 0; m_frozen = 0;
        end
      end
    end else if (a) begin
      m_busy = 0; m_pos = 0; m_frozen = 0;
    end else if (m_frozen) begin
      if (!h) m_frozen = 0;               // release edge does not step
    end else if (h) begin
      m_frozen = 1;
    end else begin
      m_pos = (m_pos + (d ? STEPS - 1 : 1)) % STEPS;
      if (m_pos == 0) begin
        m_wrap = 1;
        m_cnt++;
        if (m_cnt == m_target) begin
          m_done = 1; m_busy = 0; m_finishing = 1;
        end
      end
    end
  endtask

  // Apply inputs, clock one rising edge, advance the model, sample at negedge.
  task automatic cycle(input bit r, s, input int l, input bit d, h, a);
    reset = r; start = s; laps = LAP_W'(l); dir = d; hold = h; abort = a;
    @(posedge clk);
    model_edge(r, s, l, d, h, a);
    @(negedge clk);
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".gray"},    int'(gray),    gray_seq[m_pos]);
    check({tag, ".wrap"},    int'(wrap),    int'(m_wrap));
    check({tag, ".lap_cnt"}, int'(lap_cnt), m_cnt);
    check({tag, ".busy"},    int'(busy),    int'(m_busy));
    check({tag, ".done"},    int'(done),    int'(m_done));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit       r, s;
    int       l;
    bit       d, h, a;
    int       e_gray;
    bit       e_wrap;
    int       e_lap;
    bit       e_busy, e_done;
  } vec_t;

  vec_t vecs [18];

  int done_at, done_count, g_at12, g_at16;
  int wraps [$];

  initial begin
    reset = 1; start = 0; laps = '0; dir = 0; hold = 0; abort = 0;
    @(negedge clk);

    //           r  s  l  d  h  a   gray wrap lap busy done
    vecs[0]  = '{1, 0, 0, 0, 0, 0,  0,   0,   0,  0,   0};
    vecs[1]  = '{0, 1, 1, 0, 0, 0,  0,   0,   0,  1,   0};  // E0 accept
    vecs[2]  = '{0, 0, 0, 0, 0, 0,  1,   0,   0,  1,   0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0,  3,   0,   0,  1,   0};
    vecs[4]  = '{0, 0, 0, 0, 0, 0,  2,   0,   0,  1,   0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0,  6,   0,   0,  1,   0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0,  7,   0,   0,  1,   0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0,  5,   0,   0,  1,   0};
    vecs[8]  = '{0, 0, 0, 0, 0, 0,  4,   0,   0,  1,   0};
    vecs[9]  = '{0, 0, 0, 0, 0, 0,  0,   1,   1,  0,   1};  // E8 wrap+done
    vecs[10] = '{0, 0, 0, 0, 0, 0,  0,   0,   1,  0,   0};  // lap_cnt held
    vecs[11] = '{0, 1, 0, 0, 0, 0,  0,   0,   0,  0,   1};  // laps==0
    vecs[12] = '{0, 1, 0, 0, 0, 0,  0,   0,   0,  0,   0};  // start in DONE ignored
    vecs[13] = '{0, 1, 0, 0, 0, 0,  0,   0,   0,  0,   1};  // back-to-back
    vecs[14] = '{0, 0, 0, 0, 1, 1,  0,   0,   0,  0,   0};  // hold/abort idle
    vecs[15] = '{0, 1, 2, 1, 1, 0,  0,   0,   0,  1,   0};  // hold ignored in IDLE
    vecs[16] = '{0, 0, 0, 1, 0, 0,  4,   0,   0,  1,   0};  // first down step
    vecs[17] = '{1, 0, 0, 0, 0, 0,  0,   0,   0,  0,   0};  // reset mid-run

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].s, vecs[i].l, vecs[i].d, vecs[i].h, vecs[i].a);
      check($sformatf("vec%0d.gray", i),    int'(gray),    vecs[i].e_gray);
      check($sformatf("vec%0d.wrap", i),    int'(wrap),    int'(vecs[i].e_wrap));
      check($sformatf("vec%0d.lap_cnt", i), int'(lap_cnt), vecs[i].e_lap);
      check($sformatf("vec%0d.busy", i),    int'(busy),    int'(vecs[i].e_busy));
      check($sformatf("vec%0d.done", i),    int'(done),    int'(vecs[i].e_done));
    end

    // laps=2 down: wraps after E8 and E16, done only after E16.
    cycle(0, 1, 2, 1, 0, 0);
    done_at = -1; wraps.delete();
    for (int k = 1; k <= 20; k++) begin
      cycle(0, 0, 0, 1, 0, 0);
      compare_model("down2");
      if (k == 1) check("down2.first_gray", int'(gray), 4);
      if (wrap) wraps.push_back(k);
      if (done && done_at < 0) done_at = k;
    end
    check("down2.wrap_count", wraps.size(), 2);
    if (wraps.size() == 2) begin
      check("down2.wrap1_edge", wraps[0], STEPS);
      check("down2.wrap2_edge", wraps[1], 2 * STEPS);
    end
    check("down2.done_edge", done_at, 2 * STEPS);
    check("down2.lap_cnt", int'(lap_cnt), 2);

    // laps=3 with hold sampled high on E12..E15: five cycles spent in HOLD
    // (E12..E16, the release edge does not step), so done lands on E29.
    cycle(0, 1, 3, 0, 0, 0);
    done_at = -1; g_at12 = -1; g_at16 = -1;
    for (int k = 1; k <= 34; k++) begin
      cycle(0, 0, 0, 0, (k >= 12 && k <= 15), 0);
      compare_model("hold");
      if (k == 12) g_at12 = int'(gray);
      if (k == 16) g_at16 = int'(gray);
      if (done && done_at < 0) done_at = k;
    end
    check("hold.frozen_gray_e12", g_at12, 2);
    check("hold.frozen_gray_e16", g_at16, 2);
    check("hold.done_edge", done_at, 3 * STEPS + 5);

    // Abort at E5 of lap 1: back to IDLE, no done ever.
    cycle(0, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cycle(0, 0, 0, 0, 0, 0);
      compare_model("abort.pre");
    end
    cycle(0, 0, 0, 0, 0, 1);
    check("abort.gray", int'(gray), 0);
    check("abort.busy", int'(busy), 0);
    check("abort.lap_cnt", int'(lap_cnt), 0);
    done_count = int'(done);
    for (int k = 0; k < 12; k++) begin
      cycle(0, 0, 0, 0, 0, 0);
      compare_model("abort.post");
      done_count += int'(done);
    end
    check("abort.no_done", done_count, 0);

    // Start held during busy and during DONE: ignored, a single done at E8.
    cycle(0, 1, 1, 0, 0, 0);
    done_at = -1; done_count = 0;
    for (int k = 1; k <= 14; k++) begin
      cycle(0, ((k >= 2 && k <= 6) || k == 9), 1, 0, 0, 0);
      compare_model("busy_start");
      done_count += int'(done);
      if (done && done_at < 0) done_at = k;
    end
    check("busy_start.done_count", done_count, 1);
    check("busy_start.done_edge", done_at, STEPS);

    // Direction flip: up 2 then down 2 counts as a lap; then reset mid-run.
    cycle(0, 1, 2, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("flip.gray_up2", int'(gray), 3);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    check("flip.gray", int'(gray), 0);
    check("flip.wrap", int'(wrap), 1);
    check("flip.lap_cnt", int'(lap_cnt), 1);
    check("flip.busy", int'(busy), 1);
    check("flip.done", int'(done), 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    compare_model("flip.reset");
    check("flip.reset_lap_cnt", int'(lap_cnt), 0);
    check("flip.reset_busy", int'(busy), 0);

    // Random stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(199) == 0),
            ($urandom_range(9) < 2),
            int'($urandom_range(3)),
            bit'($urandom_range(1)),
            ($urandom_range(9) == 0),
            ($urandom_range(39) == 0));
      compare_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
